fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter PROG_LAST, default 23: highest valid program address; fetch wraps to 0 after it.
REQ-002 Parameter SYNC_STAGES, default 2: flop depth of the SW8 synchroniser.
REQ-003 Clock  input  1  single clock; all state changes on posedge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 Instruction  input  13  registered program-memory output; [12:6] opcode, [5:0] operand; equals ROM[Addr] one cycle after Addr is presented.
REQ-006 SW8  input  1  asynchronous switch input used by OP_HEI.
REQ-007 Addr  output  5  program-memory address; combinational from internal state.
REQ-008 Issue  output  1  Instruction is valid this cycle and the datapath shall execute it.
REQ-009 Waiting  output  1  high while stalled on an unsatisfied OP_HEI (LED drive).
REQ-010 PC  output  5  address of the instruction currently on Instruction.

Function
REQ-011 States: BOOT, RUN, HOLD; encoded as a 2-bit enum.
REQ-012 BOOT: Addr=0, Issue=0, Waiting=0; next cycle PC<=0, state<=RUN (covers the one-cycle memory latency).
REQ-013 next(PC) = 0 when PC==PROG_LAST, else PC+1; no address above PROG_LAST is ever driven.
REQ-014 HEI detect: Instruction[12:6]==OP_HEI; condition met when SW8_sync != Instruction[0] (operand 0 waits for SW8=1; operand 1 waits for SW8=0).
REQ-015 RUN, non-HEI: Issue=1, Addr=next(PC), PC<=next(PC); one instruction per cycle.
REQ-016 RUN, HEI with condition met: Issue=0 (HEI never reaches datapath), Addr=next(PC), PC<=next(PC), stay RUN.
REQ-017 RUN, HEI with condition unmet: Issue=0, Addr=PC, PC held, state<=HOLD.
REQ-018 HOLD: Issue=0, Waiting=1, Addr=PC (memory re-presents the HEI); on condition met, Addr=next(PC), PC<=next(PC), state<=RUN, Waiting drops same cycle.
REQ-019 SW8 edge to first post-HEI Issue: SYNC_STAGES+1 cycles maximum from the SW8 change reaching the first synchroniser flop.
REQ-020 HEI at PC==PROG_LAST wraps to 0 on release.
REQ-021 Consecutive HEIs evaluated independently; a SW8 level satisfying both passes each in one cycle.
REQ-022 Issue and Waiting never both high.

Reset
REQ-023 nReset low asynchronously forces state=BOOT, PC=0, Addr=0, Issue=0, Waiting=0, synchroniser flops=0.
REQ-024 Reset asserted mid-HOLD or mid-RUN abandons the current instruction; after release, execution restarts at address 0 via BOOT.
REQ-025 Release of nReset is synchronous to Clock externally; first posedge after release executes BOOT.

Structure
REQ-026 Opcode constants (OP_HEI etc.) and the state enum type shall live in shared package picomips_pkg; program memory and decoder import the same package.
REQ-027 SW8 synchroniser shall be a sub-module named synchroniser (parameterised depth, async active-low reset, reset value 0).
REQ-028 No other sub-modules; next-address logic combinational, state/PC in one always_ff.

Verification
REQ-029 Reset release with SW8=0, linear program (no HEI) -> Addr 0 during BOOT, then Issue=1 with PC 0,1,2,...,23,0 on consecutive cycles.
REQ-030 Program of 24 instructions, SW8 held 0, HEI operand 0 at address 0 -> Waiting=1, Addr=0 indefinitely; raise SW8 -> Waiting=0 within 3 cycles, next Issue with PC=1.
REQ-031 HEI operand 1 at address 7, SW8=1 -> HOLD at PC=7; drop SW8 -> PC=8 issued within 3 cycles; HEI never seen with Issue=1.
REQ-032 HEI operand 0 at PROG_LAST=23 with SW8 already 1 -> no stall, PC sequence 22,23,0 with Issue=1,0,1.
REQ-033 Assert nReset for 1 cycle while in HOLD at PC=17 -> outputs zero immediately (asynchronous), then BOOT, then PC=0 Issue=1.
REQ-034 SW8 toggled with 1-cycle glitch shorter than one clock during HOLD -> no release unless captured by synchroniser; Issue/Waiting mutual exclusion checked by assertion throughout.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcodes, widths and the fetch state type.
// Imported by the fetch controller, program memory and decoder.
package picomips_pkg;

   localparam int INSTR_W = 13;
   localparam int OPC_W   = 7;
   localparam int ADDR_W  = 5;

   localparam logic [OPC_W-1:0] OP_NOP  = 7'h00;
   localparam logic [OPC_W-1:0] OP_ADD  = 7'h01;
   localparam logic [OPC_W-1:0] OP_ADDI = 7'h02;
   localparam logic [OPC_W-1:0] OP_MUL  = 7'h03;
   localparam logic [OPC_W-1:0] OP_HEI  = 7'h40;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

   function automatic logic is_hei(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1:INSTR_W-OPC_W] == OP_HEI;
   endfunction

endpackage

// File: rtl/synchroniser.sv
// Multi-flop synchroniser for an asynchronous level input.
// Depth is parameterised; all flops clear to 0 on reset.
module synchroniser #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fetch_controller.sv
// picoMIPS fetch controller: sequential fetch with wrap, one-cycle boot
// for memory latency, and HEI stalls released by the synchronised SW8.
module fetch_controller
   import picomips_pkg::*;
#(
   parameter int PROG_LAST   = 23,
   parameter int SYNC_STAGES = 2
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               SW8,
   output logic [ADDR_W-1:0]  Addr,
   output logic               Issue,
   output logic               Waiting,
   output logic [ADDR_W-1:0]  PC
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_d;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_d;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_sw8_sync;
   logic              w_hei;
   logic              w_met;
   logic              w_unused_operand;

   synchroniser #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (Clock),
      .i_rst_n (nReset),
      .i_d     (SW8),
      .o_q     (w_sw8_sync)
   );

   assign w_unused_operand = ^Instruction[5:1];
   assign w_pc_next = (r_pc == ADDR_W'(PROG_LAST)) ? '0 : r_pc + 1'b1;
   assign w_hei     = is_hei(Instruction);
   // operand bit 0 names the level being waited against
   assign w_met     = w_sw8_sync != Instruction[0];
   assign PC        = r_pc;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= ST_BOOT;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      Addr      = '0;
      Issue     = 1'b0;
      Waiting   = 1'b0;
      unique case (r_state)
         ST_BOOT: begin
            w_pc_d    = '0;
            w_state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!w_hei) begin
               Issue  = 1'b1;
               Addr   = w_pc_next;
               w_pc_d = w_pc_next;
            end else if (w_met) begin
               Addr   = w_pc_next;
               w_pc_d = w_pc_next;
            end else begin
               Addr      = r_pc;
               w_state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (w_met) begin
               Addr      = w_pc_next;
               w_pc_d    = w_pc_next;
               w_state_d = ST_RUN;
            end else begin
               Waiting = 1'b1;
               Addr    = r_pc;
            end
         end
         default: begin
            w_state_d = ST_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed tables, hand
// sequences for stall/wrap/reset, and a randomised reference model.
module tb_fetch_controller;
   import picomips_pkg::*;

   localparam int LAST = 23;
   localparam int SS   = 2;

   logic        Clock = 1'b0;
   logic        nReset = 1'b0;
   logic        SW8 = 1'b0;
   logic [12:0] Instruction;
   logic [4:0]  Addr;
   logic [4:0]  PC;
   logic        Issue;
   logic        Waiting;

   logic [12:0] rom [0:31];
   int checks = 0;
   int errors = 0;

   fetch_controller #(
      .PROG_LAST   (LAST),
      .SYNC_STAGES (SS)
   ) dut (
      .Clock       (Clock),
      .nReset      (nReset),
      .Instruction (Instruction),
      .SW8         (SW8),
      .Addr        (Addr),
      .Issue       (Issue),
      .Waiting     (Waiting),
      .PC          (PC)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) Instruction <= rom[Addr];

   assert property (@(posedge Clock) !(Issue && Waiting))
      else $error("Issue and Waiting high together");

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, Addr, 0);
      chk({tag, "_issue"}, Issue, 0);
      chk({tag, "_wait"}, Waiting, 0);
      chk({tag, "_pc"}, PC, 0);
   endtask

   // reference model: PC of the instruction in flight, boot flag,
   // whether a stall has already lasted a cycle, and SW8 sample history
   int m_pc;
   bit m_boot;
   bit m_stall;
   bit m_hist[$];

   function automatic int nxt(input int p);
      return (p + 1) % (LAST + 1);
   endfunction

   task automatic model_reset();
      m_pc = 0;
      m_boot = 1;
      m_stall = 0;
      m_hist = {};
      repeat (SS) m_hist.push_front(1'b0);
   endtask

   function automatic bit model_blocked();
      logic [12:0] ins;
      ins = rom[m_pc];
      return (ins[12:6] == OP_HEI) && (m_hist[SS-1] == ins[0]);
   endfunction

   task automatic model_check();
      logic [12:0] ins;
      bit hei;
      bit blk;
      if (m_boot) begin
         chk_zero("m_boot");
      end else begin
         ins = rom[m_pc];
         hei = ins[12:6] == OP_HEI;
         blk = model_blocked();
         chk("m_pc", PC, m_pc);
         chk("m_issue", Issue, !hei);
         chk("m_wait", Waiting, blk && m_stall);
         chk("m_addr", Addr, blk ? m_pc : nxt(m_pc));
      end
      chk("hei_issued", Issue && (Instruction[12:6] == OP_HEI), 0);
   endtask

   task automatic model_step();
      if (m_boot) begin
         m_boot = 0;
         m_pc = 0;
         m_stall = 0;
      end else if (model_blocked()) begin
         m_stall = 1;
      end else begin
         m_stall = 0;
         m_pc = nxt(m_pc);
      end
      m_hist.push_front(SW8);
      void'(m_hist.pop_back());
   endtask

   task automatic load_linear();
      for (int i = 0; i < 32; i++) rom[i] = {OP_ADD, 6'(i)};
   endtask

   task automatic restart();
      nReset = 1'b0;
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
   endtask

   typedef struct {
      bit         sw8;
      logic [4:0] addr;
      bit         iss;
      bit         wt;
      logic [4:0] pc;
   } vec_t;

   vec_t tv [8];

   initial begin
      bit found;

      // HEI op0 at address 0 with SW8 low, then release
      tv[0] = '{0, 0, 0, 0, 0};
      tv[1] = '{0, 0, 0, 0, 0};
      tv[2] = '{0, 0, 0, 1, 0};
      tv[3] = '{1, 0, 0, 1, 0};
      tv[4] = '{1, 0, 0, 1, 0};
      tv[5] = '{1, 1, 0, 0, 0};
      tv[6] = '{1, 2, 1, 0, 1};
      tv[7] = '{1, 3, 1, 0, 2};

      load_linear();
      rom[0] = {OP_HEI, 6'd0};
      SW8 = 1'b0;
      repeat (3) @(negedge Clock);
      chk_zero("reset");
      nReset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tv%0d_addr", i), Addr, tv[i].addr);
         chk($sformatf("tv%0d_issue", i), Issue, tv[i].iss);
         chk($sformatf("tv%0d_wait", i), Waiting, tv[i].wt);
         chk($sformatf("tv%0d_pc", i), PC, tv[i].pc);
         SW8 = tv[i].sw8;
         @(negedge Clock);
      end

      // HEI at the last address with condition already met: no stall
      load_linear();
      rom[LAST] = {OP_HEI, 6'd0};
      SW8 = 1'b1;
      restart();
      found = 0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge Clock);
         found = (PC == 5'(LAST - 1)) && Issue;
      end
      chk("wrap_reach22", found, 1);
      @(negedge Clock);
      chk("wrap_pc23", PC, LAST);
      chk("wrap_issue23", Issue, 0);
      chk("wrap_addr23", Addr, 0);
      @(negedge Clock);
      chk("wrap_pc0", PC, 0);
      chk("wrap_issue0", Issue, 1);

      // stall at 17, sub-cycle glitch, then reset in HOLD
      load_linear();
      rom[17] = {OP_HEI, 6'd0};
      SW8 = 1'b0;
      restart();
      found = 0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge Clock);
         found = (PC == 5'd17) && Waiting;
      end
      chk("hold_reach17", found, 1);
      #1 SW8 = 1'b1;
      #2 SW8 = 1'b0;
      repeat (3) @(negedge Clock);
      chk("glitch_wait", Waiting, 1);
      chk("glitch_pc", PC, 17);
      chk("glitch_addr", Addr, 17);
      #1 nReset = 1'b0;
      #1 chk_zero("async_rst");
      @(negedge Clock);
      nReset = 1'b1;
      chk_zero("post_rst_boot");
      @(negedge Clock);
      chk("post_rst_pc", PC, 0);
      chk("post_rst_issue", Issue, 1);

      // randomised programs against the reference model
      for (int p = 0; p < 5; p++) begin
         int hei_pct;
         hei_pct = (p == 0) ? 0 : 10 + 8 * p;
         nReset = 1'b0;
         for (int a = 0; a < 32; a++) begin
            if ($urandom_range(0, 99) < hei_pct)
               rom[a] = {OP_HEI, 5'd0, 1'($urandom_range(0, 1))};
            else
               rom[a] = {OP_ADD, 6'($urandom)};
         end
         SW8 = 1'($urandom_range(0, 1));
         restart();
         model_reset();
         for (int c = 0; c < 500; c++) begin
            model_check();
            if ($urandom_range(0, 79) == 0) begin
               #1 nReset = 1'b0;
               #1 chk_zero("rnd_rst");
               @(negedge Clock);
               nReset = 1'b1;
               model_reset();
            end else begin
               if ($urandom_range(0, 7) == 0) begin
                  #1 SW8 = ~SW8;
                  #2 SW8 = ~SW8;
               end
               if ($urandom_range(0, 5) == 0) SW8 = ~SW8;
               model_step();
               @(negedge Clock);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
